pixel_port_arbiter: RTL
=======================

PIXEL_PORT_ARBITER -- requirements
Module: pixel_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning number of pixel requesters (index 0 = clear engine, 1 = erase, 2 = character draw).
REQ-002 The block SHALL have parameter MAX_BURST, default 16, meaning maximum plotted pixels per grant before forced release.
REQ-003 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port resetn  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  NUM_REQ  per-requester bus request, held high for the whole burst.
REQ-006 Port req_plot  input  NUM_REQ  per-requester pixel-valid strobe.
REQ-007 Port req_x  input  NUM_REQ*9  packed x coordinates, requester i at bits [9i+8:9i].
REQ-008 Port req_y  input  NUM_REQ*8  packed y coordinates, requester i at bits [8i+7:8i].
REQ-009 Port req_color  input  NUM_REQ*3  packed colours, requester i at bits [3i+2:3i].
REQ-010 Port grant  output  NUM_REQ  one-hot registered grant; all zero when no owner.
REQ-011 Port done  output  NUM_REQ  one-cycle pulse to the owner on release.
REQ-012 Port plot  output  1  registered VGA write strobe.
REQ-013 Port color  output  3  registered VGA pixel colour.
REQ-014 Port xCoordinate  output  9  registered VGA x.
REQ-015 Port yCoordinate  output  8  registered VGA y.
REQ-016 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT, RELEASE.
REQ-018 IDLE: if any req bit is high, the block SHALL select the winner, set grant one-hot and enter GRANT on the next edge; else remain in IDLE.
REQ-019 GRANT: each cycle the block SHALL register the owner's x, y and colour onto the outputs and set plot = req_plot[owner], giving a latency of one cycle from input to VGA port.
REQ-020 The block SHALL suppress plot (force 0) when the owner's x >= 320 or y >= 240; coordinates still pass through.
REQ-021 A 9-bit burst counter SHALL clear on grant and increment on each cycle in which plot is asserted at the output.
REQ-022 GRANT SHALL exit to RELEASE when req[owner] falls or the counter reaches MAX_BURST; simultaneous occurrence SHALL cause one release only.
REQ-023 RELEASE: the block SHALL drive plot=0, grant=0 and done[owner]=1 for exactly one cycle, then return to IDLE.
REQ-024 After a forced release, a still-requesting owner SHALL re-compete in IDLE like any other requester.
REQ-025 The block SHALL ignore req_plot, req_x, req_y and req_color of non-owners.
REQ-026 The arbitration winner SHALL be fixed priority, with index 0 highest, unless REQ-031 applies.

Reset
REQ-027 When resetn is low, the block SHALL immediately set state=IDLE, grant=0, done=0, plot=0, color=0, xCoordinate=0, yCoordinate=0, busy=0, burst counter=0 and last-owner=NUM_REQ-1.
REQ-028 On reset mid-burst, the block SHALL abandon the burst without a done pulse.
REQ-029 The first IDLE cycle after deassertion SHALL arbitrate normally.

Configuration
REQ-030 Macro PIXEL_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 With the macro defined, the winner SHALL be the first requesting index after last-owner, searched cyclically; last-owner updates on each grant.
REQ-032 Without the macro, the block SHALL use fixed priority per REQ-026, and no last-owner register SHALL be synthesised.

Structure
REQ-033 Package pixel_arb_pkg SHALL hold X_W=9, Y_W=8, C_W=3, SCREEN_W=320, SCREEN_H=240 and the FSM state enumeration.
REQ-034 Winner selection SHALL be a single sub-module arb_select (inputs req and last-owner; outputs one-hot winner and valid).

Verification
REQ-035 Clear-style burst: req[0] is held while plotting (5,20,c=3) -> one cycle later, plot=1 at x=5, y=20, color=3; grant=001.
REQ-036 Contention: req=110 in IDLE -> grant=010 under fixed priority; with the macro and last-owner=1 -> grant=100.
REQ-037 Burst cap: MAX_BURST=16, owner plots every cycle -> exactly 16 plot pulses, then a RELEASE cycle with done pulsed once and plot=0.
REQ-038 Clipping: the owner plots x=320, y=10 -> plot=0 and xCoordinate=320.
REQ-039 The owner drops req in the same cycle the counter hits MAX_BURST -> a single done pulse and a single RELEASE cycle.
REQ-040 resetn pulsed low mid-GRANT -> all outputs are 0 asynchronously, done is never pulsed, and state is IDLE.

Source files
------------

// File: rtl/pixel_arb_pkg.sv
// Shared widths, screen bounds and FSM state codes for the pixel port arbiter.
// Pure declarations: no latency, no flow control.
package pixel_arb_pkg;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int CNT_W    = 9;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_GRANT   = 2'd1;
    localparam arb_state_t ST_RELEASE = 2'd2;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } pixel_t;

    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/pixel_port_arbiter_arb_select.sv
// Combinational winner pick: fixed priority (index 0 first), or round-robin after last_owner
// when PIXEL_ARB_ROUND_ROBIN_EN is defined. Zero latency, no flow control.
module arb_select
    import pixel_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic found;

    assign valid = |req;

`ifdef PIXEL_ARB_ROUND_ROBIN_EN
    // Search starts just after the previous owner and wraps, so the previous owner is tried last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int l = 0; l < NUM_REQ; l++) begin
            if (last_owner == IDX_W'(l)) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!found && req[(l + k) % NUM_REQ]) begin
                        winner[(l + k) % NUM_REQ] = 1'b1;
                        found                     = 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/pixel_port_arbiter.sv
// Grants the VGA pixel port to one requester per burst; PIXEL_ARB_ROUND_ROBIN_EN selects round-robin.
// One cycle from owner pixel to VGA port; bursts end on req drop or after MAX_BURST plots.
module pixel_port_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_plot,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_color,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   plot,
    output logic [C_W-1:0]         color,
    output logic [X_W-1:0]         xCoordinate,
    output logic [Y_W-1:0]         yCoordinate,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               plot_q, plot_d;
    pixel_t             pix_q, pix_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic [NUM_REQ-1:0] win;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   last_sel;

    pixel_t             own_pix;
    logic               own_req;
    logic               own_plot;
    logic               burst_full;

    arb_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb_select (
        .req        (req),
        .last_owner (last_sel),
        .winner     (win),
        .valid      (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

`ifdef PIXEL_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && win_vld) begin
            last_d = win_idx;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = IDX_W'(NUM_REQ - 1);
`endif

    // Only the owner's lanes are ever looked at; everyone else's strobes and coordinates are ignored.
    always_comb begin
        own_pix  = '0;
        own_req  = 1'b0;
        own_plot = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_pix.x = req_x[i*X_W +: X_W];
                own_pix.y = req_y[i*Y_W +: Y_W];
                own_pix.c = req_color[i*C_W +: C_W];
                own_req   = req[i];
                own_plot  = req_plot[i];
            end
        end
    end

    assign burst_full = (cnt_q == CNT_W'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        plot_d  = 1'b0;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (win_vld) begin
                    state_d = ST_GRANT;
                    grant_d = win;
                    owner_d = win_idx;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                // A req drop and a full counter in the same cycle share this single exit.
                if (!own_req || burst_full) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    done_d  = grant_q;
                end else begin
                    pix_d  = own_pix;
                    plot_d = own_plot && on_screen(own_pix.x, own_pix.y);
                    cnt_d  = cnt_q + CNT_W'(plot_d);
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            plot_q  <= 1'b0;
            pix_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign plot        = plot_q;
    assign color       = pix_q.c;
    assign xCoordinate = pix_q.x;
    assign yCoordinate = pix_q.y;
    assign busy        = (state_q != ST_IDLE);

endmodule
